// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter: shares the SLC-3 on-chip memory between the CPU datapath port
// and a debug/program-load port. One requester is granted at a time. The memory
// strobes are driven for WAIT_STATES cycles, and then a one-cycle ready pulse goes
// to the owner.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration. Without it,
// the arbiter uses fixed priority with debug over CPU.
module slc3_mem_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_oe,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              busy
);

    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                win_dbg;

`ifdef MEM_ARB_RR_EN
    // last_dbg_q = 1 when debug owned the most recent grant; resets to CPU.
    logic last_dbg_q, last_dbg_d;

    assign win_dbg = dbg_req & (~cpu_req | ~last_dbg_q);

    // Record the winner of each grant so that the other port wins the next tie.
    always_comb begin
        last_dbg_d = last_dbg_q;
        if (state_q == StIdle && (cpu_req || dbg_req)) begin
            last_dbg_d = win_dbg;
        end
    end

    // Last-owner register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            last_dbg_q <= 1'b0;
        end else begin
            last_dbg_q <= last_dbg_d;
        end
    end
`else
    assign win_dbg = dbg_req;
`endif

    // Next-state logic: arbitrate and latch in IDLE, count wait states, retire in DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_req || dbg_req) begin
                    state_d = StAccess;
                    cnt_d   = CntW'(WAIT_STATES - 1);
                    grant_d = win_dbg ? 2'b10 : 2'b01;
                    we_d    = win_dbg ? dbg_we    : cpu_we;
                    addr_d  = win_dbg ? dbg_addr  : cpu_addr;
                    wdata_d = win_dbg ? dbg_wdata : cpu_wdata;
                end
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    if (!we_q) begin
                        if (grant_q[1]) begin
                            dbg_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'b00;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any access.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            grant_q     <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign mem_oe    = (state_q == StAccess) & ~we_q;
    assign mem_we    = (state_q == StAccess) & we_q;
    assign cpu_ready = (state_q == StDone) & grant_q[0];
    assign dbg_ready = (state_q == StDone) & grant_q[1];
    assign busy      = (state_q != StIdle);
    assign grant     = grant_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Self-checking bench for slc3_mem_arbiter with WAIT_STATES = 2 and a small
// behavioural memory. Arbitration expectations follow MEM_ARB_RR_EN.
module tb_slc3_mem_arbiter;

    localparam int unsigned W = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0, dbg_wdata = '0;
    logic [15:0] dbg_rdata;
    logic        dbg_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_oe, mem_we;
    logic [1:0]  grant;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] exp_cpu_rd = '0;
    logic [15:0] exp_dbg_rd = '0;

    always #5 Clk = ~Clk;

    slc3_mem_arbiter #(
        .WAIT_STATES(W),
        .ADDR_W     (16),
        .DATA_W     (16)
    ) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .dbg_req  (dbg_req),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata),
        .dbg_ready(dbg_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .grant    (grant),
        .busy     (busy)
    );

    // Behavioural memory: synchronous write, combinational read.
    logic [15:0] mem [256];
    logic        mem_init = 1'b1;
    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i) ^ 16'h0F00;
            mem[11] <= 16'h1234;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[7:0]];

    typedef struct {
        bit          dbg;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } txn_t;

    txn_t vec[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] status();
        return {grant, busy, mem_oe, mem_we, cpu_ready, dbg_ready};
    endfunction

    // One isolated transaction. Req is dropped and the inputs are scrambled right
    // after the accepting edge.
    task automatic run_txn(input txn_t t);
        logic [1:0] g;
        logic       b, oe, we, cr, dr;
        g = t.dbg ? 2'b10 : 2'b01;
        @(posedge Clk); #1;
        if (t.dbg) begin
            dbg_req = 1'b1; dbg_we = t.we; dbg_addr = t.addr; dbg_wdata = t.wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata;
        end
        @(posedge Clk); #1;
        cpu_req = 1'b0; dbg_req = 1'b0;
        cpu_addr = 16'hFFFF; dbg_addr = 16'hFFFF;
        cpu_wdata = 16'h0000; dbg_wdata = 16'h0000;
        cpu_we = ~t.we; dbg_we = ~t.we;
        if (!t.we) begin
            if (t.dbg) exp_dbg_rd = t.exp_rd;
            else exp_cpu_rd = t.exp_rd;
        end
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge Clk);
            b  = (k <= W + 1);
            oe = (k <= W) && !t.we;
            we = (k <= W) && t.we;
            cr = (k == W + 1) && !t.dbg;
            dr = (k == W + 1) && t.dbg;
            check($sformatf("txn@%0h cyc%0d status", t.addr, k), 32'(status()),
                  32'({b ? g : 2'b00, b, oe, we, cr, dr}));
            if (k == 1) begin
                check("txn mem_addr", 32'(mem_addr), 32'(t.addr));
                if (t.we) check("txn mem_wdata", 32'(mem_wdata), 32'(t.wdata));
            end
            if (k == W + 1) begin
                check("txn cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_rd));
                check("txn dbg_rdata", 32'(dbg_rdata), 32'(exp_dbg_rd));
            end
        end
    endtask

    initial begin
        int n;
        int n_dbg;
        int cyc;
        int t0;
        int t1;
        logic exp_dbg_win;

        vec[0] = '{dbg: 1'b0, we: 1'b0, addr: 16'h000B, wdata: 16'h0000, exp_rd: 16'h1234};
        vec[1] = '{dbg: 1'b1, we: 1'b1, addr: 16'h0003, wdata: 16'hBEEF, exp_rd: 16'h0000};
        vec[2] = '{dbg: 1'b0, we: 1'b0, addr: 16'h0003, wdata: 16'h0000, exp_rd: 16'hBEEF};
        vec[3] = '{dbg: 1'b1, we: 1'b0, addr: 16'h000B, wdata: 16'h0000, exp_rd: 16'h1234};
        vec[4] = '{dbg: 1'b0, we: 1'b1, addr: 16'h0010, wdata: 16'hCAFE, exp_rd: 16'h0000};
        vec[5] = '{dbg: 1'b1, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, exp_rd: 16'hCAFE};
        vec[6] = '{dbg: 1'b0, we: 1'b0, addr: 16'h0000, wdata: 16'h0000, exp_rd: 16'h0F00};

        // Reset state
        repeat (3) @(posedge Clk);
        #1 mem_init = 1'b0;
        @(negedge Clk);
        check("reset status", 32'(status()), 32'h0);
        check("reset rdata", {cpu_rdata, dbg_rdata}, 32'h0);
        check("reset mem_addr", 32'(mem_addr), 32'h0);
        @(posedge Clk); #1 Reset_n = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) run_txn(vec[i]);

        // Continuous contention, starting from a fresh reset
        @(negedge Clk) Reset_n = 1'b0;
        exp_cpu_rd = '0; exp_dbg_rd = '0;
        @(negedge Clk) Reset_n = 1'b1;
        @(posedge Clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h000B;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0003;
        n = 0; n_dbg = 0; cyc = 0;
        while (n < 8 && cyc < 8 * (W + 2) + 20) begin
            @(negedge Clk);
            cyc++;
            if (cpu_ready || dbg_ready) begin
`ifdef MEM_ARB_RR_EN
                exp_dbg_win = (n % 2 == 0);
`else
                exp_dbg_win = 1'b1;
`endif
                check($sformatf("arb grant %0d", n), 32'({cpu_ready, dbg_ready}),
                      exp_dbg_win ? 32'h1 : 32'h2);
                if (dbg_ready) n_dbg++;
                n++;
                if (n == 8) begin
                    cpu_req = 1'b0; dbg_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        check("arb access count", 32'(n), 32'd8);
`ifdef MEM_ARB_RR_EN
        check("arb debug grants", 32'(n_dbg), 32'd4);
`else
        check("arb debug grants", 32'(n_dbg), 32'd8);
`endif
        repeat (2) @(negedge Clk);
        check("arb idle after", 32'(status()), 32'h0);

        // Reset in the middle of a debug write
        @(posedge Clk); #1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0020; dbg_wdata = 16'h1111;
        @(posedge Clk); #1 dbg_req = 1'b0;
        @(negedge Clk);
        check("pre-reset mem_we", 32'(mem_we), 32'h1);
        #1 Reset_n = 1'b0;
        #1;
        check("mid reset status", 32'(status()), 32'h0);
        check("mid reset rdata", {cpu_rdata, dbg_rdata}, 32'h0);
        @(negedge Clk) Reset_n = 1'b1;
        for (int k = 0; k < 2 * W + 4; k++) begin
            @(negedge Clk);
            check($sformatf("post reset cyc%0d", k), 32'(status()), 32'h0);
        end

        // Request held across ready: back-to-back accesses W+2 apart
        @(posedge Clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h000B;
        n = 0; cyc = 0; t0 = 0; t1 = 0;
        while (n < 2 && cyc < 30) begin
            @(negedge Clk);
            cyc++;
            if (cpu_ready) begin
                if (n == 0) t0 = cyc;
                else t1 = cyc;
                n++;
                if (n == 2) cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        check("b2b pulse count", 32'(n), 32'd2);
        check("b2b spacing", 32'(t1 - t0), 32'(W + 2));
        check("b2b rdata", 32'(cpu_rdata), 32'h1234);
        repeat (2) @(negedge Clk);
        check("b2b idle after", 32'(status()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/slc3_mem_arbiter.md
# slc3_mem_arbiter

Two-port memory arbiter and access sequencer that shares the SLC-3 on-chip memory between the CPU datapath (MAR/MDR path, driven by the state controller's Mem_OE/Mem_WE) and a debug/program-load port. It grants one requester at a time and drives memory strobes for a fixed number of wait states. It returns a one-cycle ready pulse with read data to the granted requester. It sits between the SLC-3 core and the memory wrapper inside the top-level test harness.

## Interface
- WAIT_STATES, 1, memory access length in cycles; legal range 1..4
- ADDR_W, 16, address width
- DATA_W, 16, data width

- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, level; held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port, same semantics as CPU port
- dbg_rdata  out  DATA_W  debug read data, valid with dbg_ready
- dbg_ready  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered memory write data
- mem_oe  out  1  memory output enable
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data
- grant  out  2  one-hot owner: [0] = CPU, [1] = debug; 00 when idle
- busy  out  1  high in ACCESS and DONE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req is high, arbitrate, then latch addr/wdata/we of the winner into the mem_* registers. Set grant and load the wait counter with WAIT_STATES-1. Go to ACCESS. With no req, stay in IDLE with grant = 00.
- Arbitration: fixed priority, debug over CPU. Alternate arbitration is described under Configuration.
- ACCESS: on reads, mem_oe = 1 for every ACCESS cycle; on writes, mem_we = 1 for every ACCESS cycle. The counter decrements each cycle. When the counter reaches 0, a read captures mem_rdata into the winner's rdata register, and the FSM goes to DONE.
- DONE: pulse the winner's ready for exactly one cycle. Strobes, grant and busy clear on exit. Go to IDLE.
- The losing port's ready stays 0. Its rdata register holds its last value.
- If req drops during ACCESS, the access still completes and ready still pulses.
- If req is still high in the IDLE cycle after DONE, it is a new transaction. A requester must drop req in the cycle ready is sampled if it wants only one access.
- Address, data and we are sampled only in IDLE. Input changes during ACCESS are ignored.
- Reset (asynchronous, any state): state = IDLE. All outputs = 0, including mem_oe, mem_we, both rdata registers, grant and busy. An interrupted access produces no ready pulse.

## Timing
- Request first seen high at edge N (state IDLE): ACCESS occupies cycles N+1..N+WAIT_STATES, and ready is high in cycle N+WAIT_STATES+1.
- Request-to-ready latency is WAIT_STATES+1 cycles. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- mem_rdata is sampled at the edge ending the last ACCESS cycle. rdata is valid from the ready cycle and holds until the next read completes on that port.
- At most one of mem_oe and mem_we is high in any cycle. Both are 0 in IDLE and DONE.
- Simultaneous requests in IDLE produce exactly one grant. The loser is served in the next IDLE cycle in which it is still requesting and wins arbitration.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A 1-bit last-owner register updates on each grant. On a tie, the port that did not win last is granted. Reset value is last-owner = CPU, so debug wins the first tie after reset.
- MEM_ARB_RR_EN undefined: fixed priority, debug over CPU. The last-owner register is not built. The CPU can starve while dbg_req stays high.

## Test plan
- CPU read, WAIT_STATES=2, memory at 0x000B holds 0x1234. Raise cpu_req with addr 0x000B at edge N. Required: mem_oe high in cycles N+1..N+2, cpu_ready high only in N+3, cpu_rdata = 0x1234, dbg_ready = 0.
- Debug write of 0xBEEF to 0x0003. Required: mem_we high for exactly WAIT_STATES cycles with mem_addr = 0x0003 and mem_wdata = 0xBEEF. Then one dbg_ready pulse; a CPU read of 0x0003 afterwards returns 0xBEEF.
- Both ports request continuously; count grants over 8 accesses. Required without MEM_ARB_RR_EN: 8 debug grants, 0 CPU. Required with MEM_ARB_RR_EN: grants alternate D, C, D, C, ..., 4 each.
- cpu_req dropped, and cpu_addr changed to 0xFFFF, during the first ACCESS cycle. Required: the access completes on the original address and cpu_ready still pulses once.
- Reset_n pulsed low mid-ACCESS during a write. Required: mem_we, grant, busy and both rdata registers go to 0 immediately, with no subsequent ready pulse. The FSM is in IDLE after release.
- cpu_req held high across ready. Required: a second access starts in the IDLE cycle after DONE, giving ready pulses exactly WAIT_STATES+2 cycles apart.
